spi_flash_responder: RTL and testbench
======================================

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 24, flash byte-address width.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for flash_csb/flash_clk/flash_io0_di.
REQ-003 SHALL have port clk  input  1  system clock; only clock domain.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flash_csb  input  1  chip select from SPI initiator, active-low.
REQ-006 SHALL have port flash_clk  input  1  SPI mode-0 serial clock from initiator.
REQ-007 SHALL have port flash_io0_di  input  1  serial data in (MOSI).
REQ-008 SHALL have port flash_io1_do  output  1  serial data out (MISO).
REQ-009 SHALL have port flash_io1_oe  output  1  MISO output enable.
REQ-010 SHALL have port mem_valid  output  1  backing-memory read request.
REQ-011 SHALL have port mem_ready  input  1  backing-memory read complete.
REQ-012 SHALL have port mem_addr  output  ADDR_BITS  word-aligned read address, {addr[ADDR_BITS-1:2],2'b00}.
REQ-013 SHALL have port mem_rdata  input  32  read word, little-endian (byte 0 = bits 7:0).

Function
REQ-014 SHALL pass flash_csb, flash_clk and flash_io0_di through SYNC_STAGES flops each, detect flash_clk edges on synchronized values; supported SCK <= clk/8.
REQ-015 SHALL sample MOSI on each SCK rising edge and shift MISO, MSB first, on each SCK falling edge.
REQ-016 SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
REQ-017 SHALL go IDLE->CMD on synchronized csb falling edge, clearing bit counter.
REQ-018 SHALL, after 8 command bits, go CMD->ADDR on 0x03 and CMD->IGNORE on any other command, including 0xAB.
REQ-019 SHALL, after ADDR_BITS address bits, latch the byte address, issue a fetch for its word, and enter DATA.
REQ-020 SHALL assert mem_valid with stable mem_addr until the cycle mem_ready is high, then deassert next cycle; at most one request outstanding.
REQ-021 SHALL buffer the fetched word and serve successive bytes from it, issuing a new fetch only when the address crosses into a new word.
REQ-022 SHALL issue the fetch for the next word as soon as the last byte of the current word is loaded into the shift register.
REQ-023 SHALL increment the byte address after each byte; address wraps from all-ones to 0.
REQ-024 SHALL, if the word needed for a byte is not buffered at that byte's MSB falling edge, transmit 0xFF for that byte (underrun) and still advance the address.
REQ-025 SHALL assert flash_io1_oe only in DATA while csb low; in all other states oe=0 and flash_io1_do=0.
REQ-026 SHALL, on csb rising edge in any state, return to IDLE within 1 cycle of the synchronized edge and drop oe.
REQ-027 SHALL not abort an outstanding fetch on csb rise: mem_valid holds until mem_ready, and the data is discarded.
REQ-028 SHALL ignore SCK edges in IDLE and IGNORE.

Reset
REQ-029 SHALL, while rst low, force state IDLE, mem_valid=0, mem_addr=0, flash_io1_oe=0, flash_io1_do=0, counters and buffers cleared, synchronizers to csb=1/clk=0.
REQ-030 SHALL leave reset synchronously to clk; a transaction in progress at reset is lost and the responder waits for the next csb falling edge.

Configuration
REQ-031 SHALL, with SPI_FLASH_RESPONDER_FAST_READ_EN defined, accept command 0x0B: after address go ADDR->DUMMY for 8 SCK cycles (fetch issued at DUMMY entry), then DATA.
REQ-032 SHALL, without SPI_FLASH_RESPONDER_FAST_READ_EN, treat 0x0B as unknown (->IGNORE) and contain no DUMMY logic.

Verification
REQ-033 SHALL cover: cmd 0x03, addr 0x000004, word@0x4=0x44332211, 4 bytes -> MISO 0x11,0x22,0x33,0x44; exactly one mem request, mem_addr=0x000004.
REQ-034 SHALL cover: 0x03, addr 0x000003, 2 bytes, word@0=0xAA000000, word@4=0x000000BB -> 0xAA,0xBB; requests at 0x000000 then 0x000004.
REQ-035 SHALL cover: 0x03, addr 0xFFFFFF, 2 bytes -> second request at mem_addr 0x000000.
REQ-036 SHALL cover: cmd 0x9F then 32 SCKs -> flash_io1_oe stays 0, mem_valid never asserted.
REQ-037 SHALL cover: mem_ready withheld beyond first data falling edge -> byte 0xFF; csb raised with request pending, mem_ready after 20 cycles -> mem_valid held until ready, then IDLE, oe=0.
REQ-038 SHALL cover, macro defined: 0x0B, addr 0x000004, 8 dummy SCKs -> 0x11 after dummies; macro undefined -> oe stays 0.

Source files
------------

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 serial-flash read responder backed by a 32-bit word memory.
// Serves READ (0x03) from a one-word buffer with next-word prefetch; other commands are ignored.
// Optional feature macro: SPI_FLASH_RESPONDER_FAST_READ_EN adds FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_responder #(
  parameter int unsigned ADDR_BITS   = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flash_csb,
  input  logic                 flash_clk,
  input  logic                 flash_io0_di,
  output logic                 flash_io1_do,
  output logic                 flash_io1_oe,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [31:0]          mem_rdata
);

  localparam int unsigned WADDR_W = ADDR_BITS - 2;
  localparam int unsigned CNT_W   = $clog2(ADDR_BITS + 9);
  localparam logic [7:0]  CMD_READ = 8'h03;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  localparam logic [7:0]  CMD_FAST_READ = 8'h0B;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
`endif

  state_t state;

  logic [SYNC_STAGES-1:0] csb_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] di_sync;
  logic                   csb_q;
  logic                   sck_q;

  logic [CNT_W-1:0]     bit_cnt;
  logic [6:0]           cmd_sr;
  logic [ADDR_BITS-2:0] addr_sr;
  logic [ADDR_BITS-1:0] byte_addr;
  logic [6:0]           tx_sr;
  logic                 fetch_go;
  logic [WADDR_W-1:0]   fetch_waddr;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  logic                 fast;
`endif

  logic                 fetch_pend;
  logic [WADDR_W-1:0]   pend_waddr;
  logic                 discard;
  logic                 buf_valid;
  logic [WADDR_W-1:0]   buf_tag;
  logic [31:0]          buf_word;

  logic                 csb_s;
  logic                 sck_s;
  logic                 di_s;
  logic                 csb_fall_c;
  logic                 csb_rise_c;
  logic                 sck_rise_c;
  logic                 sck_fall_c;
  logic [7:0]           cmd_next_c;
  logic [ADDR_BITS-1:0] addr_next_c;
  logic [ADDR_BITS-1:0] addr_inc_c;
  logic                 buf_hit_c;
  logic [7:0]           load_byte_c;

  // Synchronizers for the SPI pins plus one extra stage for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csb_sync <= '1;
      sck_sync <= '0;
      di_sync  <= '0;
      csb_q    <= 1'b1;
      sck_q    <= 1'b0;
    end else begin
      csb_sync <= SYNC_STAGES'({csb_sync, flash_csb});
      sck_sync <= SYNC_STAGES'({sck_sync, flash_clk});
      di_sync  <= SYNC_STAGES'({di_sync, flash_io0_di});
      csb_q    <= csb_s;
      sck_q    <= sck_s;
    end
  end

  // Edge strobes, shift-register next values and the byte to present next
  always_comb begin
    csb_s       = csb_sync[SYNC_STAGES-1];
    sck_s       = sck_sync[SYNC_STAGES-1];
    di_s        = di_sync[SYNC_STAGES-1];
    csb_fall_c  = csb_q & ~csb_s;
    csb_rise_c  = ~csb_q & csb_s;
    sck_rise_c  = ~sck_q & sck_s;
    sck_fall_c  = sck_q & ~sck_s;
    cmd_next_c  = {cmd_sr, di_s};
    addr_next_c = {addr_sr, di_s};
    addr_inc_c  = byte_addr + ADDR_BITS'(1);
    buf_hit_c   = buf_valid && (buf_tag == byte_addr[ADDR_BITS-1:2]);
    load_byte_c = buf_hit_c ? 8'(buf_word >> {byte_addr[1:0], 3'b000}) : 8'hFF;
  end

  // Protocol FSM: command/address decode and MISO shifting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      cmd_sr       <= '0;
      addr_sr      <= '0;
      byte_addr    <= '0;
      tx_sr        <= '0;
      fetch_go     <= 1'b0;
      fetch_waddr  <= '0;
      flash_io1_do <= 1'b0;
      flash_io1_oe <= 1'b0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
      fast         <= 1'b0;
`endif
    end else begin
      fetch_go <= 1'b0;
      if (csb_rise_c) begin
        state        <= IDLE;
        flash_io1_oe <= 1'b0;
        flash_io1_do <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (csb_fall_c) begin
              state   <= CMD;
              bit_cnt <= '0;
            end
          end
          CMD: begin
            if (sck_rise_c) begin
              cmd_sr <= cmd_next_c[6:0];
              if (bit_cnt == CNT_W'(7)) begin
                bit_cnt <= '0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                fast    <= (cmd_next_c == CMD_FAST_READ);
                if (cmd_next_c == CMD_READ || cmd_next_c == CMD_FAST_READ) state <= ADDR;
                else state <= IGNORE;
`else
                if (cmd_next_c == CMD_READ) state <= ADDR;
                else state <= IGNORE;
`endif
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          ADDR: begin
            if (sck_rise_c) begin
              addr_sr <= addr_next_c[ADDR_BITS-2:0];
              if (bit_cnt == CNT_W'(ADDR_BITS - 1)) begin
                bit_cnt     <= '0;
                byte_addr   <= addr_next_c;
                fetch_go    <= 1'b1;
                fetch_waddr <= addr_next_c[ADDR_BITS-1:2];
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                if (fast) begin
                  state <= DUMMY;
                end else begin
                  state        <= DATA;
                  flash_io1_oe <= 1'b1;
                end
`else
                state        <= DATA;
                flash_io1_oe <= 1'b1;
`endif
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
          DUMMY: begin
            if (sck_rise_c) begin
              if (bit_cnt == CNT_W'(7)) begin
                bit_cnt      <= '0;
                state        <= DATA;
                flash_io1_oe <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
`endif
          DATA: begin
            if (sck_fall_c) begin
              if (bit_cnt == '0) begin
                // New byte: present MSB now, underrun yields 0xFF, prefetch on word crossing
                flash_io1_do <= load_byte_c[7];
                tx_sr        <= load_byte_c[6:0];
                byte_addr    <= addr_inc_c;
                if (byte_addr[1:0] == 2'b11) begin
                  fetch_go    <= 1'b1;
                  fetch_waddr <= addr_inc_c[ADDR_BITS-1:2];
                end
              end else begin
                flash_io1_do <= tx_sr[6];
                tx_sr        <= {tx_sr[5:0], 1'b0};
              end
              bit_cnt <= (bit_cnt == CNT_W'(7)) ? '0 : bit_cnt + CNT_W'(1);
            end
          end
          IGNORE: begin
            state <= IGNORE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Backing-memory handshake and one-word read buffer; stale responses are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      fetch_pend <= 1'b0;
      pend_waddr <= '0;
      discard    <= 1'b0;
      buf_valid  <= 1'b0;
      buf_tag    <= '0;
      buf_word   <= '0;
    end else begin
      if (mem_valid) begin
        if (mem_ready) begin
          mem_valid <= 1'b0;
          discard   <= 1'b0;
          if (!discard) begin
            buf_valid <= 1'b1;
            buf_tag   <= mem_addr[ADDR_BITS-1:2];
            buf_word  <= mem_rdata;
          end
        end
      end else if (fetch_pend && !csb_rise_c) begin
        mem_valid  <= 1'b1;
        mem_addr   <= {pend_waddr, 2'b00};
        fetch_pend <= 1'b0;
      end
      if (fetch_go) begin
        fetch_pend <= 1'b1;
        pend_waddr <= fetch_waddr;
      end
      if (csb_rise_c) begin
        fetch_pend <= 1'b0;
        buf_valid  <= 1'b0;
        if (mem_valid && !mem_ready) discard <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed SPI initiator, word-memory responder and reference model.
module tb_spi_flash_responder;

  localparam int unsigned AW   = 24;
  localparam int unsigned HALF = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flash_csb = 1'b1;
  logic          flash_clk = 1'b0;
  logic          flash_io0_di = 1'b0;
  logic          flash_io1_do;
  logic          flash_io1_oe;
  logic          mem_valid;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  logic [31:0]   mem [int unsigned];
  logic [AW-1:0] req_log[$];
  logic [7:0]    rx_q[$];
  int            mem_lat = 0;
  bit            mem_hold = 1'b0;
  bit            oe_allowed = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic          prev_valid = 1'b0;

  spi_flash_responder #(.ADDR_BITS(AW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0_di(flash_io0_di),
    .flash_io1_do(flash_io1_do), .flash_io1_oe(flash_io1_oe),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory contents as seen by the flash: unwritten words hold an address-derived pattern
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    int unsigned w;
    w = 32'(a >> 2);
    if (mem.exists(w)) return mem[w];
    return 32'hC0DE0000 ^ w;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [AW-1:0] a);
    logic [31:0] wd;
    wd = mem_word(a);
    return wd[8*a[1:0] +: 8];
  endfunction

  // Memory responder: answer each request after mem_lat cycles unless held
  initial begin
    forever begin
      @(negedge clk);
      if (mem_valid === 1'b1) begin
        req_log.push_back(mem_addr);
        while (mem_hold) @(negedge clk);
        repeat (mem_lat) @(negedge clk);
        mem_rdata = mem_word(mem_addr);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
      end
    end
  end

  // Per-cycle output rules
  always @(negedge clk) begin
    if (rst) begin
      if (!oe_allowed) chk("oe_outside_data", 32'(flash_io1_oe), 32'd0);
      if (flash_io1_oe !== 1'b1) chk("do_while_oe_low", 32'(flash_io1_do), 32'd0);
      if (mem_valid === 1'b1 && prev_valid === 1'b1) chk("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
      if (mem_valid === 1'b1) chk("mem_addr_aligned", 32'(mem_addr[1:0]), 32'd0);
    end
    prev_valid = mem_valid;
    prev_addr  = mem_addr;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI byte, MSB first; MISO captured at each SCK rising edge
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      flash_io0_di = tx[i];
      tick(HALF);
      rx[i] = flash_io1_do;
      flash_clk = 1'b1;
      tick(HALF);
      flash_clk = 1'b0;
    end
  endtask

  task automatic cs_start();
    flash_csb = 1'b0;
    tick(6);
  endtask

  task automatic cs_stop();
    tick(4);
    flash_csb = 1'b1;
    tick(8);
    oe_allowed = 1'b0;
    tick(4);
  endtask

  task automatic wait_mem_idle();
    int n;
    n = 0;
    while ((mem_valid !== 1'b0 || mem_ready) && n < 400) begin
      tick(1);
      n++;
    end
    chk("mem_idle_timeout", 32'(n >= 400), 32'd0);
  endtask

  // Read transaction checked against the model: bytes, oe, and the fetch sequence
  task automatic do_read(input string name, input logic [7:0] cmd, input logic [AW-1:0] addr,
                         input int nbytes, input int ndummy, input bit under0);
    logic [7:0]    rx;
    logic [7:0]    exp;
    logic [AW-1:0] a;
    logic [AW-1:0] a1;
    logic [AW-1:0] exp_req[$];
    req_log.delete();
    rx_q.delete();
    cs_start();
    xfer(cmd, rx);
    for (int b = 2; b >= 0; b--) begin
      if (b == 0 && ndummy == 0) oe_allowed = 1'b1;
      xfer(addr[8*b +: 8], rx);
    end
    for (int d = 0; d < ndummy; d++) begin
      if (d == ndummy - 1) oe_allowed = 1'b1;
      xfer(8'h00, rx);
    end
    exp_req.push_back({addr[AW-1:2], 2'b00});
    for (int i = 0; i < nbytes; i++) begin
      xfer(8'h00, rx);
      a   = addr + AW'(i);
      exp = (i == 0 && under0) ? 8'hFF : exp_byte(a);
      chk({name, "_byte"}, 32'(rx), 32'(exp));
      chk({name, "_oe"}, 32'(flash_io1_oe), 32'd1);
      rx_q.push_back(rx);
      if (a[1:0] == 2'b11) begin
        a1 = a + AW'(1);
        exp_req.push_back({a1[AW-1:2], 2'b00});
      end
    end
    cs_stop();
    wait_mem_idle();
    chk({name, "_nreq"}, 32'(req_log.size()), 32'(exp_req.size()));
    for (int i = 0; i < exp_req.size() && i < req_log.size(); i++)
      chk({name, "_req"}, 32'(req_log[i]), 32'(exp_req[i]));
  endtask

  // Non-read command followed by 32 SCKs: no output enable, no fetch
  task automatic do_ignore(input string name, input logic [7:0] cmd, input logic [31:0] tail);
    logic [7:0] rx;
    req_log.delete();
    cs_start();
    xfer(cmd, rx);
    for (int b = 3; b >= 0; b--) xfer(tail[8*b +: 8], rx);
    chk({name, "_oe"}, 32'(flash_io1_oe), 32'd0);
    cs_stop();
    wait_mem_idle();
    chk({name, "_nreq"}, 32'(req_log.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] rx;
    int         lows;
    int         n4;

    // Reset values
    tick(5);
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_oe", 32'(flash_io1_oe), 32'd0);
    chk("rst_do", 32'(flash_io1_do), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    rst = 1'b1;
    tick(5);
    chk("post_rst_valid", 32'(mem_valid), 32'd0);
    chk("post_rst_oe", 32'(flash_io1_oe), 32'd0);

    // Four bytes from one word; the served word is fetched once (the next word is prefetched)
    mem[1] = 32'h44332211;
    do_read("read4", 8'h03, 24'h000004, 4, 0, 1'b0);
    chk("read4_b0", 32'(rx_q[0]), 32'h11);
    chk("read4_b1", 32'(rx_q[1]), 32'h22);
    chk("read4_b2", 32'(rx_q[2]), 32'h33);
    chk("read4_b3", 32'(rx_q[3]), 32'h44);
    if (req_log.size() > 0) chk("read4_first_req", 32'(req_log[0]), 32'h000004);
    n4 = 0;
    foreach (req_log[i]) if (req_log[i] == 24'h000004) n4++;
    chk("read4_word4_fetches", 32'(n4), 32'd1);

    // Crossing a word boundary
    mem[0] = 32'hAA000000;
    mem[1] = 32'h000000BB;
    do_read("cross", 8'h03, 24'h000003, 2, 0, 1'b0);
    chk("cross_b0", 32'(rx_q[0]), 32'hAA);
    chk("cross_b1", 32'(rx_q[1]), 32'hBB);
    if (req_log.size() > 1) begin
      chk("cross_req0", 32'(req_log[0]), 32'h000000);
      chk("cross_req1", 32'(req_log[1]), 32'h000004);
    end

    // Address wrap from all-ones to zero
    mem[32'h003FFFFF] = 32'h77665544;
    mem[0] = 32'h123456C3;
    do_read("wrap", 8'h03, 24'hFFFFFF, 2, 0, 1'b0);
    chk("wrap_b0", 32'(rx_q[0]), 32'h77);
    chk("wrap_b1", 32'(rx_q[1]), 32'hC3);
    if (req_log.size() > 1) chk("wrap_req1", 32'(req_log[1]), 32'h000000);

    // Unsupported commands
    do_ignore("cmd9f", 8'h9F, 32'hA5A5A5A5);
    do_ignore("cmdab", 8'hAB, 32'h00000004);

    // Reset in the middle of a command; the responder must recover for the next frame
    cs_start();
    xfer(8'h03, rx);
    xfer(8'h00, rx);
    rst = 1'b0;
    tick(1);
    chk("midrst_valid", 32'(mem_valid), 32'd0);
    chk("midrst_oe", 32'(flash_io1_oe), 32'd0);
    flash_csb = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(6);

    // Slow memory: the first byte underruns, the second is served from the late word
    mem[4] = 32'h88776655;
    mem_lat = 40;
    do_read("under", 8'h03, 24'h000010, 2, 0, 1'b1);
    chk("under_b0", 32'(rx_q[0]), 32'hFF);
    chk("under_b1", 32'(rx_q[1]), 32'h66);
    mem_lat = 0;

    // csb rises while a fetch is outstanding; the request must persist until mem_ready
    mem_hold = 1'b1;
    req_log.delete();
    cs_start();
    xfer(8'h03, rx);
    xfer(8'h00, rx);
    xfer(8'h00, rx);
    oe_allowed = 1'b1;
    xfer(8'h20, rx);
    tick(2);
    flash_csb = 1'b1;
    tick(6);
    oe_allowed = 1'b0;
    chk("pend_oe_after_csb", 32'(flash_io1_oe), 32'd0);
    chk("pend_valid_after_csb", 32'(mem_valid), 32'd1);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (mem_valid !== 1'b1) lows++;
    end
    chk("pend_valid_held", 32'(lows), 32'd0);
    mem_hold = 1'b0;
    wait_mem_idle();
    tick(2);
    chk("pend_valid_dropped", 32'(mem_valid), 32'd0);
    chk("pend_oe_idle", 32'(flash_io1_oe), 32'd0);
    chk("pend_nreq", 32'(req_log.size()), 32'd1);
    if (req_log.size() > 0) chk("pend_req0", 32'(req_log[0]), 32'h000020);

    // Back in IDLE: a fresh read works
    mem[1] = 32'h44332211;
    do_read("after", 8'h03, 24'h000004, 1, 0, 1'b0);
    chk("after_b0", 32'(rx_q[0]), 32'h11);

`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    do_read("fast", 8'h0B, 24'h000004, 1, 1, 1'b0);
    chk("fast_b0", 32'(rx_q[0]), 32'h11);
`else
    do_ignore("cmd0b", 8'h0B, 32'h00000400);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
